// File: rtl/instr_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_pkg
//  Brief    : Shared opcode constants, FSM state type and default program
//             image for the program instruction memory.
//  Revision : 1.0 - initial release
// ============================================================================
package instr_mem_pkg;

    // Opcode encodings as they appear in the default program image
    localparam logic [5:0] c_op_nop  = 6'd0;
    localparam logic [5:0] c_op_ld0  = 6'd9;
    localparam logic [5:0] c_op_ld1  = 6'd10;
    localparam logic [5:0] c_op_add  = 6'd17;
    localparam logic [5:0] c_op_stra = 6'd32;
    localparam logic [5:0] c_op_br   = 6'd33;

    // Controller states: INIT copies the default image, RUN serves traffic
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Default program word for a given address; everything past 16 is a NOP
    function automatic logic [7:0] default_image_word(input logic [31:0] addr);
        logic [7:0] w_word;
        case (addr)
            32'd0:   w_word = {2'b00, c_op_nop};
            32'd1:   w_word = {2'b00, c_op_br};
            32'd2:   w_word = {2'b00, c_op_ld0};
            32'd3:   w_word = {2'b00, c_op_stra};
            32'd4:   w_word = {2'b00, c_op_ld1};
            32'd5:   w_word = {2'b00, c_op_stra};
            32'd6:   w_word = {2'b00, c_op_add};
            32'd7:   w_word = 8'd18;
            32'd8:   w_word = {2'b00, c_op_ld0};
            32'd9:   w_word = {2'b00, c_op_stra};
            32'd10:  w_word = 8'd18;
            32'd11:  w_word = {2'b00, c_op_add};
            32'd12:  w_word = {2'b00, c_op_ld1};
            32'd13:  w_word = 8'd45;
            32'd14:  w_word = 8'd11;
            32'd15:  w_word = 8'd44;
            32'd16:  w_word = 8'd27;
            default: w_word = {2'b00, c_op_nop};
        endcase
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_array.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_array
//  Brief    : DEPTH x WORD_W storage with one synchronous write port and one
//             synchronous read port (read-before-write on address collision).
//  Revision : 1.0 - initial release
// ============================================================================
module instr_mem_array #(
    parameter int IDX_W  = 5,
    parameter int DEPTH  = 32,
    parameter int WORD_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [0:DEPTH-1];
    logic [WORD_W-1:0] r_rdata;

    // Storage write; contents are rebuilt by the controller after reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; samples the pre-write contents on a same-address write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/prog_instr_mem.sv
`default_nettype none
// ============================================================================
//  Module   : prog_instr_mem
//  Brief    : Program instruction memory. Loads a default image after reset,
//             then serves one-cycle-latency fetches and loader writes.
//             Optional even-parity protection: define PROG_INSTR_MEM_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_instr_mem
    import instr_mem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 6,
    parameter int DEPTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_valid,
    output logic [INSTR_W-1:0] instr,
    input  logic               load_valid,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    output logic               load_ready,
    output logic               load_err,
    output logic               init_done,
    output logic               parity_err
);

    localparam int                c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(DEPTH - 1);
`ifdef PROG_INSTR_MEM_PARITY_EN
    localparam int                c_word_w = INSTR_W + 1;
`else
    localparam int                c_word_w = INSTR_W;
`endif

    state_t               r_state;
    logic [c_idx_w-1:0]   r_ptr;
    logic                 r_fetch_valid;
    logic                 r_zero;
    logic                 r_load_err;
    logic                 r_load_ready;
    logic                 r_init_done;

    logic                 w_fetch_in_range;
    logic                 w_load_in_range;
    logic                 w_fetch_acc;
    logic                 w_load_acc;
    logic [INSTR_W-1:0]   w_init_word;
    logic                 w_we;
    logic [c_idx_w-1:0]   w_waddr;
    logic [INSTR_W-1:0]   w_wdata_raw;
    logic [c_word_w-1:0]  w_wdata;
    logic                 w_re;
    logic [c_word_w-1:0]  w_rdata;
    logic                 w_par_bad;

    assign w_fetch_in_range = ({1'b0, fetch_addr} < c_depth);
    assign w_load_in_range  = ({1'b0, load_addr} < c_depth);
    assign w_fetch_acc      = fetch_req && (r_state == ST_RUN);
    assign w_load_acc       = load_valid && r_load_ready;
    assign w_init_word      = INSTR_W'(default_image_word(32'(r_ptr)));

    // Write-port arbitration: INIT owns the port, afterwards in-range loads
    always_comb begin
        w_we        = 1'b0;
        w_waddr     = r_ptr;
        w_wdata_raw = w_init_word;
        if (r_state == ST_INIT) begin
            w_we = 1'b1;
        end else if (w_load_acc && w_load_in_range) begin
            w_we        = 1'b1;
            w_waddr     = load_addr[c_idx_w-1:0];
            w_wdata_raw = load_data;
        end
    end

    // Out-of-range fetches skip the array; r_zero forces their result to 0
    assign w_re = w_fetch_acc && w_fetch_in_range;

`ifdef PROG_INSTR_MEM_PARITY_EN
    assign w_wdata   = {^w_wdata_raw, w_wdata_raw};
    assign w_par_bad = (^w_rdata) && !r_zero;
`else
    assign w_wdata   = w_wdata_raw;
    assign w_par_bad = 1'b0;
`endif

    instr_mem_array #(
        .IDX_W  (c_idx_w),
        .DEPTH  (DEPTH),
        .WORD_W (c_word_w)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (fetch_addr[c_idx_w-1:0]),
        .o_rdata (w_rdata)
    );

    // Controller: image copy in INIT, fetch/load bookkeeping in RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_INIT;
            r_ptr         <= '0;
            r_fetch_valid <= 1'b0;
            r_zero        <= 1'b1;
            r_load_err    <= 1'b0;
            r_load_ready  <= 1'b0;
            r_init_done   <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_acc;
            r_load_err    <= w_load_acc && !w_load_in_range;
            if (w_fetch_acc) begin
                r_zero <= !w_fetch_in_range;
            end
            case (r_state)
                ST_INIT: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == c_last) begin
                        r_state      <= ST_RUN;
                        r_ptr        <= '0;
                        r_load_ready <= 1'b1;
                        r_init_done  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_load_ready <= 1'b1;
                    r_init_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_INIT;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    assign fetch_valid = r_fetch_valid;
    assign instr       = (r_zero || w_par_bad) ? '0 : w_rdata[INSTR_W-1:0];
    assign load_err    = r_load_err;
    assign load_ready  = r_load_ready;
    assign init_done   = r_init_done;
    assign parity_err  = r_fetch_valid && w_par_bad;

endmodule
`default_nettype wire

// File: tb/tb_prog_instr_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_instr_mem
//  Brief    : Self-checking bench for prog_instr_mem against an array-based
//             reference model of the memory contents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prog_instr_mem;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_req;
    logic [7:0] fetch_addr;
    logic       fetch_valid;
    logic [5:0] instr;
    logic       load_valid;
    logic [7:0] load_addr;
    logic [5:0] load_data;
    logic       load_ready;
    logic       load_err;
    logic       init_done;
    logic       parity_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] ref_mem [0:31];
    logic [5:0] exp_instr;
    int         img [0:16] = '{0, 33, 9, 32, 10, 32, 17, 18, 9, 32, 18, 17, 10, 45, 11, 44, 27};

    prog_instr_mem #(
        .ADDR_W  (8),
        .INSTR_W (6),
        .DEPTH   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .instr       (instr),
        .load_valid  (load_valid),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_err    (load_err),
        .init_done   (init_done),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic load_image();
        for (int i = 0; i < 32; i++) ref_mem[i] = 6'd0;
        for (int i = 0; i < 17; i++) ref_mem[i] = 6'(img[i]);
        exp_instr = 6'd0;
    endtask

    // One RUN-mode cycle: drive, predict from the model, then compare
    task automatic step(input logic req, input logic [7:0] fa,
                        input logic lv, input logic [7:0] la, input logic [5:0] ld);
        logic exp_fv;
        logic exp_lerr;
        @(negedge clk);
        fetch_req  = req;
        fetch_addr = fa;
        load_valid = lv;
        load_addr  = la;
        load_data  = ld;
        exp_fv = req;
        if (req) exp_instr = (fa < 8'd32) ? ref_mem[fa[4:0]] : 6'd0;
        exp_lerr = lv && (la >= 8'd32);
        if (lv && la < 8'd32) ref_mem[la[4:0]] = ld;
        @(posedge clk);
        #1;
        check_eq("fetch_valid", fetch_valid, exp_fv);
        check_eq("instr", instr, exp_instr);
        check_eq("load_err", load_err, exp_lerr);
        check_eq("parity_err", parity_err, 1'b0);
        check_eq("load_ready", load_ready, 1'b1);
        fetch_req  = 1'b0;
        load_valid = 1'b0;
    endtask

    // Count cycles from reset release until init_done, with fetches requested
    task automatic wait_init();
        int cycles;
        bit ready_early;
        bit fv_seen;
        cycles = 0;
        ready_early = 0;
        fv_seen = 0;
        fetch_req = 1'b1;
        fetch_addr = 8'd1;
        while (cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (fetch_valid) fv_seen = 1;
            if (init_done) break;
            if (load_ready) ready_early = 1;
        end
        fetch_req = 1'b0;
        check_eq("init_cycles", cycles, 32);
        check_eq("ready_before_done", ready_early, 1'b0);
        check_eq("fetch_during_init", fv_seen, 1'b0);
        check_eq("ready_after_init", load_ready, 1'b1);
        check_eq("instr_after_init", instr, 6'd0);
        load_image();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_fv"}, fetch_valid, 1'b0);
        check_eq({tag, "_instr"}, instr, 6'd0);
        check_eq({tag, "_lready"}, load_ready, 1'b0);
        check_eq({tag, "_lerr"}, load_err, 1'b0);
        check_eq({tag, "_perr"}, parity_err, 1'b0);
        check_eq({tag, "_idone"}, init_done, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        fetch_req = 1'b0;
        fetch_addr = '0;
        load_valid = 1'b0;
        load_addr = '0;
        load_data = '0;
        load_image();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        wait_init();

        // Default image, back-to-back, then an out-of-range fetch
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, 8'd0, 6'd0);
        step(1'b1, 8'd20, 1'b0, 8'd0, 6'd0);

        // Load then fetch; same-cycle fetch+load returns the old word
        step(1'b0, 8'd0, 1'b1, 8'd5, 6'h3F);
        step(1'b1, 8'd5, 1'b0, 8'd0, 6'd0);
        check_eq("load5_fetch", instr, 6'h3F);
        step(1'b1, 8'd6, 1'b1, 8'd6, 6'h15);
        check_eq("rbw_old", instr, 6'd17);
        step(1'b1, 8'd6, 1'b0, 8'd0, 6'd0);
        check_eq("rbw_new", instr, 6'h15);

        // Out-of-range load is rejected, hold behaviour on idle cycles
        step(1'b0, 8'd0, 1'b1, 8'd40, 6'h2A);
        step(1'b1, 8'd40, 1'b0, 8'd0, 6'd0);
        step(1'b0, 8'd0, 1'b0, 8'd0, 6'd0);
        step(1'b1, 8'd31, 1'b0, 8'd0, 6'd0);
        step(1'b0, 8'd0, 1'b0, 8'd0, 6'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [7:0] fa;
            logic [7:0] la;
            fa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
            la = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
            step(1'($urandom_range(0, 1)), fa, 1'($urandom_range(0, 1)), la, 6'($urandom_range(0, 63)));
        end

        // Reset during RUN discards loads
        step(1'b0, 8'd0, 1'b1, 8'd2, 6'h3F);
        step(1'b1, 8'd2, 1'b0, 8'd0, 6'd0);
        check_eq("load2_fetch", instr, 6'h3F);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        wait_init();
        step(1'b1, 8'd2, 1'b0, 8'd0, 6'd0);
        check_eq("reinit_addr2", instr, 6'd9);

        // Reset in the middle of INIT restarts the image copy
        step(1'b1, 8'd0, 1'b1, 8'd3, 6'h01);
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midinit_rst");
        @(negedge clk);
        rst = 1'b0;
        wait_init();
        for (int i = 0; i < 34; i++) step(1'b1, 8'(i), 1'b0, 8'd0, 6'd0);

`ifdef PROG_INSTR_MEM_PARITY_EN
        // Corrupt one stored bit and expect a parity error on fetch
        @(negedge clk);
        dut.u_array.r_mem[1] = dut.u_array.r_mem[1] ^ 7'd1;
        fetch_req = 1'b1;
        fetch_addr = 8'd1;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        check_eq("par_fv", fetch_valid, 1'b1);
        check_eq("par_err", parity_err, 1'b1);
        check_eq("par_instr", instr, 6'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_instr_mem.md
PROG_INSTR_MEM -- requirements
Module: prog_instr_mem

Interface
REQ-001 Parameter: ADDR_W, 8, address width of fetch and load ports.
REQ-002 Parameter: INSTR_W, 6, instruction word width.
REQ-003 Parameter: DEPTH, 32, number of stored words; legal range 1..2^ADDR_W.
REQ-004 Port: clk  in  1  single clock for all logic.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: fetch_req  in  1  fetch request, sampled each cycle.
REQ-007 Port: fetch_addr  in  ADDR_W  fetch address.
REQ-008 Port: fetch_valid  out  1  one-cycle pulse marking valid instr.
REQ-009 Port: instr  out  INSTR_W  fetched instruction, registered.
REQ-010 Port: load_valid  in  1  loader write request.
REQ-011 Port: load_addr  in  ADDR_W  loader write address.
REQ-012 Port: load_data  in  INSTR_W  loader write data.
REQ-013 Port: load_ready  out  1  loader may write this cycle.
REQ-014 Port: load_err  out  1  one-cycle pulse: accepted load had an out-of-range address.
REQ-015 Port: init_done  out  1  high once the default image is in place.
REQ-016 Port: parity_err  out  1  one-cycle pulse with fetch_valid on a parity mismatch.

Function
REQ-017 FSM states: INIT and RUN; reset enters INIT with an internal init pointer of 0.
REQ-018 INIT writes one default-image word per cycle at pointer p, increments p, and moves to RUN after writing p = DEPTH-1 (DEPTH cycles total).
REQ-019 Default image at addresses 0..16: 0,33,9,32,10,32,17,18,9,32,18,17,10,45,11,44,27 (decimal, truncated/zero-extended to INSTR_W); all other addresses hold 0 (NOP).
REQ-020 In INIT: load_ready=0, init_done=0, and fetch_req is ignored (no fetch_valid).
REQ-021 In RUN: init_done=1 and load_ready=1.
REQ-022 Fetch latency: fetch_req high in RUN at cycle N -> fetch_valid=1 at cycle N+1, with instr = mem[fetch_addr sampled at N]; back-to-back requests give one result per cycle.
REQ-023 Fetch with fetch_addr >= DEPTH returns instr=0 with fetch_valid=1.
REQ-024 instr holds its last value when fetch_valid=0.
REQ-025 A load is accepted when load_valid && load_ready; data is written at the clock edge and is visible to fetches requested on the following cycle or later.
REQ-026 Accepted load with load_addr >= DEPTH: no write; load_err=1 on the next cycle.
REQ-027 Simultaneous fetch and load to the same address in one cycle: the fetch returns the old word (read-before-write); the new word is stored.
REQ-028 DEPTH = 2^ADDR_W: every address is in range; load_err and the REQ-023 path never fire.

Reset
REQ-029 rst asserted asynchronously forces fetch_valid=0, instr=0, load_ready=0, load_err=0, parity_err=0, init_done=0, and state INIT.
REQ-030 Reset asserted during RUN discards all loaded contents; INIT rewrites the full default image after release.
REQ-031 Reset asserted mid-INIT restarts INIT from p=0.

Configuration
REQ-032 Macro PROG_INSTR_MEM_PARITY_EN defined: each word stores an extra even-parity bit, written by INIT and by loads and checked on fetch; on a mismatch parity_err=1 with fetch_valid, and instr=0.
REQ-033 Macro undefined: no parity storage; parity_err is tied to 0.

Structure
REQ-034 Shared package instr_mem_pkg holds opcode constants (NOP, LD0, LD1, STRA, ADD, BR), the FSM state enum, and the default-image constant function.
REQ-035 Storage lives in sub-module instr_mem_array: DEPTH x (INSTR_W [+1 parity]), one synchronous write port and one synchronous read port.

Verification
REQ-036 Release reset, count cycles -> init_done rises exactly DEPTH cycles later (32); load_ready is 0 until then.
REQ-037 RUN, fetch addresses 0..16 back-to-back -> 17 fetch_valid pulses in consecutive cycles returning 0,33,9,...,44,27; addr 20 -> 0.
REQ-038 Load addr 5 = 6'h3F, then fetch 5 -> 0x3F; same-cycle fetch+load at addr 6 with data 0x15 -> returns 17; a later fetch returns 0x15.
REQ-039 Load addr 40 (DEPTH=32) -> load_err pulse, no write; fetch 40 -> 0.
REQ-040 Load addr 2 = 0x3F, assert rst mid-RUN -> after re-init, fetch 2 returns 9.
REQ-041 With PROG_INSTR_MEM_PARITY_EN, force a flipped stored bit at addr 1 -> fetch 1 gives parity_err=1 and instr=0.
